mb_instructor: RTL and testbench

MB_INSTRUCTOR -- requirements
Module: mb_instructor

---
 rtl/mb_instructor.sv | 211 +++++++++++++++++++++
 tb/tb_mb_instructor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mb_instructor.sv
// Infix expression evaluator: reads tokens from an external RAM, converts them to
// postfix with shunting-yard, then evaluates the postfix using a 32-bit signed operand stack.
module mb_instructor (
  input  logic        CLK_1MHz,
  input  logic        RSTN,
  input  logic        inf_start,
  input  logic [35:0] do_inf,
  input  logic [8:0]  top_addr_inf,
  output logic        en_inf,
  output logic [8:0]  addr_inf,
  output logic [31:0] result,
  output logic        finish,
  output logic        overflow,
  output logic        dv_by_zero,
  output logic        syntax_error
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVERT = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [11:0] C_LP  = 12'h150;
  localparam logic [11:0] C_RP  = 12'h151;
  localparam logic [11:0] C_ADD = 12'h170;
  localparam logic [11:0] C_SUB = 12'h171;
  localparam logic [11:0] C_MUL = 12'h190;
  localparam logic [11:0] C_DIV = 12'h191;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic [2:0]  state_q, state_d;
  logic [8:0]  idx_q, idx_d, top_q, top_d, addr_q, addr_d;
  logic [8:0]  pf_n_q, pf_n_d, ev_q, ev_d;
  logic [5:0]  op_sp_q, op_sp_d, vs_sp_q, vs_sp_d;
  logic [35:0] tok_q, tok_d;
  logic [31:0] result_q, result_d;
  logic        en_q, en_d, pend_q, pend_d, hold_q, hold_d, expect_q, expect_d;
  logic        finish_q, finish_d, ovf_q, ovf_d, dvz_q, dvz_d, syn_q, syn_d;

  logic [35:0] pf_mem [0:511];
  logic [11:0] op_mem [0:31];
  logic [31:0] vs_mem [0:31];
  logic        pf_we, op_we, vs_we;
  logic [8:0]  pf_wa;
  logic [35:0] pf_wd;
  logic [4:0]  op_wa, vs_wa;
  logic [11:0] op_wd;
  logic [31:0] vs_wd;

  logic [35:0]        tok, pf_ent;
  logic [11:0]        code, op_top, ev_code;
  logic signed [31:0] va, vb, divisor, quot;
  logic signed [32:0] sum;
  logic signed [63:0] prod;
  logic               div_min_neg, is_binop, err, next_tok;

  // A token is consumed straight off the RAM bus once, then replayed from tok_q while popping.
  assign tok      = pend_q ? do_inf : tok_q;
  assign code     = tok[11:0];
  assign is_binop = (code == C_ADD) || (code == C_SUB) || (code == C_MUL) || (code == C_DIV);
  assign op_top   = op_mem[op_sp_q[4:0] - 5'd1];
  assign pf_ent   = pf_mem[ev_q];
  assign ev_code  = pf_ent[11:0];
  assign va       = vs_mem[vs_sp_q[4:0] - 5'd2];
  assign vb       = vs_mem[vs_sp_q[4:0] - 5'd1];
  assign sum      = ev_code[0] ? ({va[31], va} - {vb[31], vb}) : ({va[31], va} + {vb[31], vb});
  assign prod     = va * vb;
  assign div_min_neg = (va == INT_MIN) && (vb == 32'hFFFF_FFFF);
  // Divisor is substituted for 0 and MIN/-1 so the divider never sees an undefined case.
  assign divisor  = ((vb == 32'sd0) || div_min_neg) ? 32'sd1 : vb;
  assign quot     = va / divisor;

  always_comb begin
    state_d = state_q;   idx_d = idx_q;       top_d = top_q;       addr_d = addr_q;
    pf_n_d = pf_n_q;     ev_d = ev_q;         op_sp_d = op_sp_q;   vs_sp_d = vs_sp_q;
    tok_d = tok_q;       result_d = result_q; en_d = 1'b0;         pend_d = en_q;
    hold_d = 1'b0;       expect_d = expect_q; finish_d = finish_q; ovf_d = ovf_q;
    dvz_d = dvz_q;       syn_d = syn_q;
    pf_we = 1'b0; pf_wa = pf_n_q; pf_wd = tok;
    op_we = 1'b0; op_wa = op_sp_q[4:0]; op_wd = code;
    vs_we = 1'b0; vs_wa = vs_sp_q[4:0]; vs_wd = pf_ent[31:0];
    err = 1'b0; next_tok = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (inf_start) begin
          result_d = '0; finish_d = 1'b0; ovf_d = 1'b0; dvz_d = 1'b0; syn_d = 1'b0;
          top_d = top_addr_inf; op_sp_d = '0; pf_n_d = '0; vs_sp_d = '0; ev_d = '0;
          expect_d = 1'b1;
          if (top_addr_inf == 9'd0) err = 1'b1;
          else begin
            idx_d = 9'd1; addr_d = 9'd1; en_d = 1'b1; state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        if (pend_q || hold_q) begin
          tok_d = tok;
          if (tok[35:32] == 4'h0) begin
            if (!expect_q) err = 1'b1;
            else begin
              pf_we = 1'b1; pf_n_d = pf_n_q + 9'd1; expect_d = 1'b0; next_tok = 1'b1;
            end
          end else if (tok[35:32] != 4'h1) err = 1'b1;
          else if (code == C_LP) begin
            if (!expect_q || op_sp_q == 6'd32) err = 1'b1;
            else begin
              op_we = 1'b1; op_sp_d = op_sp_q + 6'd1; next_tok = 1'b1;
            end
          end else if (code == C_RP) begin
            if (expect_q || op_sp_q == 6'd0) err = 1'b1;
            else if (op_top == C_LP) begin
              op_sp_d = op_sp_q - 6'd1; next_tok = 1'b1;
            end else begin
              pf_we = 1'b1; pf_wd = {4'h1, 20'h0, op_top}; pf_n_d = pf_n_q + 9'd1;
              op_sp_d = op_sp_q - 6'd1; hold_d = 1'b1;
            end
          end else if (is_binop) begin
            if (expect_q) err = 1'b1;
            else if (op_sp_q != 6'd0 && op_top != C_LP && op_top[7:4] >= code[7:4]) begin
              pf_we = 1'b1; pf_wd = {4'h1, 20'h0, op_top}; pf_n_d = pf_n_q + 9'd1;
              op_sp_d = op_sp_q - 6'd1; hold_d = 1'b1;
            end else if (op_sp_q == 6'd32) err = 1'b1;
            else begin
              op_we = 1'b1; op_sp_d = op_sp_q + 6'd1; expect_d = 1'b1; next_tok = 1'b1;
            end
          end else err = 1'b1;

          if (next_tok) begin
            if (idx_q == top_q) state_d = S_FLUSH;
            else begin
              idx_d = idx_q + 9'd1; addr_d = idx_q + 9'd1; en_d = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (expect_q) err = 1'b1;
        else if (op_sp_q == 6'd0) state_d = S_EVAL;
        else if (op_top == C_LP) err = 1'b1;
        else begin
          pf_we = 1'b1; pf_wd = {4'h1, 20'h0, op_top}; pf_n_d = pf_n_q + 9'd1;
          op_sp_d = op_sp_q - 6'd1;
        end
      end
      S_EVAL: begin
        if (ev_q == pf_n_q) begin
          if (vs_sp_q != 6'd1) err = 1'b1;
          else begin
            result_d = vs_mem[0]; finish_d = 1'b1; state_d = S_DONE;
          end
        end else if (pf_ent[35:32] == 4'h0) begin
          if (vs_sp_q == 6'd32) err = 1'b1;
          else begin
            vs_we = 1'b1; vs_sp_d = vs_sp_q + 6'd1; ev_d = ev_q + 9'd1;
          end
        end else if (vs_sp_q < 6'd2) err = 1'b1;
        else begin
          ev_d = ev_q + 9'd1; vs_sp_d = vs_sp_q - 6'd1;
          vs_we = 1'b1; vs_wa = vs_sp_q[4:0] - 5'd2;
          if (ev_code == C_ADD || ev_code == C_SUB) begin
            vs_wd = sum[31:0];
            if (sum[32] != sum[31]) ovf_d = 1'b1;
          end else if (ev_code == C_MUL) begin
            vs_wd = prod[31:0];
            if (prod[63:31] != '0 && prod[63:31] != '1) ovf_d = 1'b1;
          end else if (vb == 32'sd0) begin
            vs_we = 1'b0; dvz_d = 1'b1; result_d = '0; finish_d = 1'b1; state_d = S_DONE;
          end else begin
            vs_wd = div_min_neg ? INT_MIN : quot;
            if (div_min_neg) ovf_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err) begin
      syn_d = 1'b1; finish_d = 1'b1; result_d = '0; en_d = 1'b0; state_d = S_DONE;
    end
  end

  always_ff @(posedge CLK_1MHz) begin
    if (pf_we) pf_mem[pf_wa] <= pf_wd;
    if (op_we) op_mem[op_wa] <= op_wd;
    if (vs_we) vs_mem[vs_wa] <= vs_wd;
  end

  always_ff @(posedge CLK_1MHz or posedge RSTN) begin
    if (RSTN) begin
      state_q <= S_IDLE; idx_q <= '0; top_q <= '0; addr_q <= '0; pf_n_q <= '0; ev_q <= '0;
      op_sp_q <= '0; vs_sp_q <= '0; tok_q <= '0; result_q <= '0; en_q <= 1'b0;
      pend_q <= 1'b0; hold_q <= 1'b0; expect_q <= 1'b1; finish_q <= 1'b0;
      ovf_q <= 1'b0; dvz_q <= 1'b0; syn_q <= 1'b0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; top_q <= top_d; addr_q <= addr_d;
      pf_n_q <= pf_n_d; ev_q <= ev_d; op_sp_q <= op_sp_d; vs_sp_q <= vs_sp_d;
      tok_q <= tok_d; result_q <= result_d; en_q <= en_d; pend_q <= pend_d;
      hold_q <= hold_d; expect_q <= expect_d; finish_q <= finish_d;
      ovf_q <= ovf_d; dvz_q <= dvz_d; syn_q <= syn_d;
    end
  end

  assign en_inf       = en_q;
  assign addr_inf     = addr_q;
  assign result       = result_q;
  assign finish       = finish_q;
  assign overflow     = ovf_q;
  assign dv_by_zero   = dvz_q;
  assign syntax_error = syn_q;
endmodule

// File: tb/tb_mb_instructor.sv
// Directed bench for mb_instructor: a behavioural infix RAM feeds hand-written expressions.
module tb_mb_instructor;
  logic        clk = 1'b0;
  logic        rst;
  logic        inf_start;
  logic [35:0] do_inf = '0;
  logic [8:0]  top_addr_inf;
  logic        en_inf;
  logic [8:0]  addr_inf;
  logic [31:0] result;
  logic        finish, overflow, dv_by_zero, syntax_error;

  logic [35:0] ram [0:511];
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  localparam logic [11:0] LP = 12'h150, RP = 12'h151, ADD = 12'h170, SUB = 12'h171;
  localparam logic [11:0] MUL = 12'h190, DIV = 12'h191;

  always #5 clk = ~clk;

  always @(posedge clk) if (en_inf) do_inf <= ram[addr_inf];

  mb_instructor dut (
    .CLK_1MHz(clk), .RSTN(rst), .inf_start(inf_start), .do_inf(do_inf),
    .top_addr_inf(top_addr_inf), .en_inf(en_inf), .addr_inf(addr_inf), .result(result),
    .finish(finish), .overflow(overflow), .dv_by_zero(dv_by_zero), .syntax_error(syntax_error)
  );

  function automatic logic [35:0] N(input logic [31:0] v);
    return {4'h0, v};
  endfunction

  function automatic logic [35:0] O(input logic [11:0] c);
    return {4'h1, 20'h0, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string t, input logic [31:0] r, input logic o,
                            input logic d, input logic s);
    check({t, ".result"}, result, r);
    check({t, ".overflow"}, {31'd0, overflow}, {31'd0, o});
    check({t, ".dv_by_zero"}, {31'd0, dv_by_zero}, {31'd0, d});
    check({t, ".syntax_error"}, {31'd0, syntax_error}, {31'd0, s});
  endtask

  // Start held high for three cycles; top_addr_inf is scrambled after acceptance.
  task automatic run(input string t, input logic [8:0] top);
    int unsigned cyc;
    int unsigned bound;
    bound = 32'(top) * 32'd4 + 32'd16;
    top_addr_inf = top;
    @(negedge clk);
    inf_start = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (top != 9'd0) begin
      check({t, ".finish_clear"}, {31'd0, finish}, 32'd0);
      top_addr_inf = 9'h1FF;
    end
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    inf_start = 1'b0;
    while (finish !== 1'b1 && cyc <= bound) begin
      @(negedge clk);
      cyc++;
    end
    check({t, ".finish_in_bound"}, {31'd0, finish}, 32'd1);
  endtask

  task automatic load_req027();
    ram[1] = N(32'd24); ram[2] = O(SUB); ram[3] = O(LP); ram[4] = N(32'd5);
    ram[5] = O(ADD);    ram[6] = N(32'd8); ram[7] = O(RP); ram[8] = O(MUL);
    ram[9] = N(32'd4);
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, ".result"}, result, 32'd0);
    check({t, ".finish"}, {31'd0, finish}, 32'd0);
    check({t, ".flags"}, {29'd0, overflow, dv_by_zero, syntax_error}, 32'd0);
    check({t, ".en_inf"}, {31'd0, en_inf}, 32'd0);
    check({t, ".addr_inf"}, {23'd0, addr_inf}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;
    rst = 1'b1;
    inf_start = 1'b0;
    top_addr_inf = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    load_req027();
    run("mixed", 9'd9);
    expect_out("mixed", 32'hFFFF_FFE4, 1'b0, 1'b0, 1'b0);

    ram[1] = N(32'd7); ram[2] = O(DIV); ram[3] = N(32'd0);
    run("divzero", 9'd3);
    expect_out("divzero", 32'd0, 1'b0, 1'b1, 1'b0);

    ram[1] = O(LP); ram[2] = N(32'd3); ram[3] = O(ADD); ram[4] = N(32'd4);
    run("open_paren", 9'd4);
    expect_out("open_paren", 32'd0, 1'b0, 1'b0, 1'b1);

    ram[1] = N(32'h7FFF_FFFF); ram[2] = O(ADD); ram[3] = N(32'd1);
    run("add_ovf", 9'd3);
    expect_out("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0);

    ram[1] = N(32'hFFFF_FFF9); ram[2] = O(DIV); ram[3] = N(32'd2);
    run("div_trunc", 9'd3);
    expect_out("div_trunc", 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

    ram[1] = N(32'd2); ram[2] = O(ADD); ram[3] = N(32'd3); ram[4] = O(MUL); ram[5] = N(32'd4);
    run("precedence", 9'd5);
    expect_out("precedence", 32'd14, 1'b0, 1'b0, 1'b0);

    // Asynchronous clear while holding a finished result, mid-cycle with no clock edge.
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_done");
    @(negedge clk) rst = 1'b0;

    ram[1] = N(32'd20); ram[2] = O(SUB); ram[3] = N(32'd5); ram[4] = O(SUB); ram[5] = N(32'd3);
    run("left_assoc_sub", 9'd5);
    expect_out("left_assoc_sub", 32'd12, 1'b0, 1'b0, 1'b0);

    ram[1] = N(32'd100); ram[2] = O(DIV); ram[3] = N(32'd5); ram[4] = O(DIV); ram[5] = N(32'd2);
    run("left_assoc_div", 9'd5);
    expect_out("left_assoc_div", 32'd10, 1'b0, 1'b0, 1'b0);

    ram[1] = N(32'h8000_0000); ram[2] = O(DIV); ram[3] = N(32'hFFFF_FFFF);
    run("min_div_neg1", 9'd3);
    expect_out("min_div_neg1", 32'h8000_0000, 1'b1, 1'b0, 1'b0);

    ram[1] = N(32'h0001_0000); ram[2] = O(MUL); ram[3] = N(32'h0001_0000);
    run("mul_ovf", 9'd3);
    expect_out("mul_ovf", 32'd0, 1'b1, 1'b0, 1'b0);

    ram[1] = N(32'hFFFF_FFFD); ram[2] = O(MUL); ram[3] = N(32'd5);
    run("mul_neg", 9'd3);
    expect_out("mul_neg", 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);

    ram[1] = O(ADD); ram[2] = N(32'd3);
    run("lead_op", 9'd2);
    expect_out("lead_op", 32'd0, 1'b0, 1'b0, 1'b1);

    ram[1] = N(32'd3); ram[2] = N(32'd4);
    run("two_operands", 9'd2);
    expect_out("two_operands", 32'd0, 1'b0, 1'b0, 1'b1);

    ram[1] = N(32'd3); ram[2] = O(RP);
    run("close_paren", 9'd2);
    expect_out("close_paren", 32'd0, 1'b0, 1'b0, 1'b1);

    ram[1] = N(32'd3); ram[2] = O(ADD);
    run("trail_op", 9'd2);
    expect_out("trail_op", 32'd0, 1'b0, 1'b0, 1'b1);

    ram[1] = N(32'd3); ram[2] = O(12'h172); ram[3] = N(32'd4);
    run("bad_code", 9'd3);
    expect_out("bad_code", 32'd0, 1'b0, 1'b0, 1'b1);

    run("empty", 9'd0);
    expect_out("empty", 32'd0, 1'b0, 1'b0, 1'b1);

    // Reset during evaluation: postfix evaluation of this program spans cycles 23..30.
    load_req027();
    top_addr_inf = 9'd9;
    @(negedge clk) inf_start = 1'b1;
    @(negedge clk) inf_start = 1'b0;
    repeat (25) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_eval");
    @(negedge clk) rst = 1'b0;
    run("after_reset", 9'd9);
    expect_out("after_reset", 32'hFFFF_FFE4, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
